// File: rtl/epp_pkg.sv
// epp_pkg: shared types and constants for the EPP register port
package epp_pkg;
   localparam int EPP_DW = 8;
   typedef enum logic [2:0] {IDLE, SETUP, CAPT, ACK, DONE} state_e;
   typedef enum logic {KIND_DATA = 1'b0, KIND_ADDR = 1'b1} kind_e;
   typedef enum logic {DIR_WR = 1'b0, DIR_RD = 1'b1} dir_e;
endpackage

// File: rtl/epp_sync.sv
// epp_sync: 2-flop synchroniser, resets to 1 so idle-high strobes stay inactive
module epp_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;
   // shift the async input through two flops
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff_q <= 2'b11;
      else        ff_q <= {ff_q[0], d_i};
   assign q_o = ff_q[1];
endmodule

// File: rtl/epp_reg_port.sv
// epp_reg_port: EPP slave front-end for the register file; ACK timeout via EPP_TIMEOUT_EN
module epp_reg_port
   import epp_pkg::*;
#(
   parameter int AW        = 5,
   parameter int SETUP_CYC = 2,
   parameter int TO_CYC    = 1023
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              nAddrStr,
   input  logic              nDataStr,
   input  logic              nWrite,
   input  logic [EPP_DW-1:0] pport_din,
   output logic [EPP_DW-1:0] pport_dout,
   output logic              pport_oe,
   output logic              nWait,
   output logic [AW-1:0]     addr,
   output logic              wr_stb,
   output logic [EPP_DW-1:0] wr_data,
   output logic              rd_stb,
   input  logic [EPP_DW-1:0] rd_data,
   output logic              timeout,
   input  logic              timeout_clr
);
   localparam int CW = $clog2(SETUP_CYC + 1);

   logic              a_s, d_s, w_s, a_act, d_act, any_act;
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   kind_e             kind_q, kind_d;
   dir_e              dir_q, dir_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [EPP_DW-1:0] wr_data_q, wr_data_d, dout_q, dout_d;
   logic              wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
   logic              timeout_q, timeout_d;
`ifdef EPP_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC + 1);
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
`else
   logic              unused_cfg;
   assign unused_cfg = timeout_clr & (TO_CYC > 0);
`endif

   epp_sync u_sync_a (.clk(clk), .rst_n(nReset), .d_i(nAddrStr), .q_o(a_s));
   epp_sync u_sync_d (.clk(clk), .rst_n(nReset), .d_i(nDataStr), .q_o(d_s));
   epp_sync u_sync_w (.clk(clk), .rst_n(nReset), .d_i(nWrite),   .q_o(w_s));

   assign a_act   = ~a_s;
   assign d_act   = ~d_s;
   assign any_act = a_act | d_act;

   // state and datapath registers
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         kind_q    <= KIND_DATA;
         dir_q     <= DIR_WR;
         addr_q    <= '0;
         wr_data_q <= '0;
         dout_q    <= '0;
         wr_stb_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         timeout_q <= 1'b0;
`ifdef EPP_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         kind_q    <= kind_d;
         dir_q     <= dir_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         dout_q    <= dout_d;
         wr_stb_q  <= wr_stb_d;
         rd_stb_q  <= rd_stb_d;
         timeout_q <= timeout_d;
`ifdef EPP_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end

   // handshake sequencing; the pad byte is sampled only on the SETUP->CAPT edge
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      kind_d    = kind_q;
      dir_d     = dir_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      dout_d    = dout_q;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      timeout_d = timeout_q;
`ifdef EPP_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
`endif
      case (state_q)
         IDLE:
            if (any_act) begin
               state_d = SETUP;
               cnt_d   = CW'(SETUP_CYC - 1);
               kind_d  = a_act ? KIND_ADDR : KIND_DATA;
               dir_d   = dir_e'(w_s);
            end
         SETUP:
            if (!any_act) state_d = IDLE;
            else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
               state_d = CAPT;
               if (dir_q == DIR_WR) begin
                  if (kind_q == KIND_ADDR) addr_d = pport_din[AW-1:0];
                  else begin
                     wr_data_d = pport_din;
                     wr_stb_d  = 1'b1;
                  end
               end else if (kind_q == KIND_DATA) rd_stb_d = 1'b1;
            end
         CAPT: begin
            state_d = ACK;
`ifdef EPP_TIMEOUT_EN
            to_cnt_d = '0;
`endif
            if (dir_q == DIR_RD) dout_d = (kind_q == KIND_DATA) ? rd_data : EPP_DW'(addr_q);
         end
         ACK:
            if (!any_act) state_d = DONE;
`ifdef EPP_TIMEOUT_EN
            else if (to_cnt_q == TW'(TO_CYC - 1)) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else to_cnt_d = to_cnt_q + 1'b1;
`endif
         DONE: begin
            state_d = IDLE;
            if (kind_q == KIND_DATA) addr_d = addr_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
`ifdef EPP_TIMEOUT_EN
      if (timeout_clr) timeout_d = 1'b0;
`endif
   end

   assign nWait      = (state_q != ACK);
   assign pport_oe   = (state_q == ACK) && (dir_q == DIR_RD);
   assign pport_dout = dout_q;
   assign addr       = addr_q;
   assign wr_stb     = wr_stb_q;
   assign wr_data    = wr_data_q;
   assign rd_stb     = rd_stb_q;
   assign timeout    = timeout_q;
endmodule

// File: tb/tb_epp_reg_port.sv
// tb_epp_reg_port: directed self-checking bench for epp_reg_port
module tb_epp_reg_port;
   logic       clk = 1'b0;
   logic       nReset, nAddrStr, nDataStr, nWrite, timeout_clr;
   logic [7:0] pport_din, pport_dout, wr_data, rd_data;
   logic       pport_oe, nWait, wr_stb, rd_stb, timeout;
   logic [4:0] addr;

   int checks = 0, failures = 0, rd_cnt = 0;
   logic saw_ack = 1'b0;
   logic [4:0] wr_addr_q[$];
   logic [7:0] wr_dat_q[$];

   always #5 clk = ~clk;

   // register-file model: read byte is the address times three
   assign rd_data = 8'(addr) * 8'd3;

   epp_reg_port #(.TO_CYC(16)) dut (
      .clk(clk), .nReset(nReset), .nAddrStr(nAddrStr), .nDataStr(nDataStr), .nWrite(nWrite),
      .pport_din(pport_din), .pport_dout(pport_dout), .pport_oe(pport_oe), .nWait(nWait),
      .addr(addr), .wr_stb(wr_stb), .wr_data(wr_data), .rd_stb(rd_stb), .rd_data(rd_data),
      .timeout(timeout), .timeout_clr(timeout_clr)
   );

   always @(negedge clk) begin
      if (wr_stb) begin
         wr_addr_q.push_back(addr);
         wr_dat_q.push_back(wr_data);
      end
      if (rd_stb) rd_cnt++;
      if (!nWait) saw_ack = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic epp_cycle(input logic a, input logic d, input logic rd, input logic [7:0] din,
                            output logic acked, output logic [7:0] dout, output logic oe);
      @(negedge clk);
      nWrite = rd;
      pport_din = din;
      nAddrStr = !a;
      nDataStr = !d;
      acked = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!nWait) begin
            acked = 1'b1;
            break;
         end
      end
      dout = pport_dout;
      oe = pport_oe;
      nAddrStr = 1'b1;
      nDataStr = 1'b1;
      for (int i = 0; i < 20 && !nWait; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      nWrite = 1'b1;
   endtask

   initial begin
      logic       ack, oe;
      logic [7:0] dout;
      logic [7:0] wd [3];
      int n, rc;
      wd = '{8'h11, 8'h22, 8'h33};
      nReset = 1'b0; nAddrStr = 1'b1; nDataStr = 1'b1; nWrite = 1'b1;
      pport_din = 8'h00; timeout_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_addr", addr, 0);
      check("rst_nwait", nWait, 1);
      check("rst_oe", pport_oe, 0);
      check("rst_wr_stb", wr_stb, 0);
      check("rst_rd_stb", rd_stb, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_dout", pport_dout, 0);
      check("rst_timeout", timeout, 0);
      nReset = 1'b1;
      repeat (2) @(negedge clk);

      epp_cycle(1, 0, 0, 8'h05, ack, dout, oe);
      check("aw05_ack", ack, 1);
      check("aw05_addr", addr, 5);
      check("aw05_no_wr", wr_addr_q.size(), 0);
      for (int i = 0; i < 3; i++) begin
         epp_cycle(0, 1, 0, wd[i], ack, dout, oe);
         check("dw_ack", ack, 1);
      end
      check("dw_count", wr_addr_q.size(), 3);
      for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
         check("dw_addr", wr_addr_q[i], 5 + i);
         check("dw_data", wr_dat_q[i], wd[i]);
      end
      check("dw_addr_end", addr, 8);

      epp_cycle(1, 0, 0, 8'h1F, ack, dout, oe);
      check("aw1f_addr", addr, 5'h1F);
      rc = rd_cnt;
      epp_cycle(0, 1, 1, 8'h00, ack, dout, oe);
      check("dr_ack", ack, 1);
      check("dr_dout", dout, 8'h5D);
      check("dr_oe", oe, 1);
      check("dr_rd_stb", rd_cnt, rc + 1);
      check("dr_wrap", addr, 0);

      epp_cycle(1, 0, 0, 8'h13, ack, dout, oe);
      epp_cycle(1, 0, 1, 8'h00, ack, dout, oe);
      check("ar_dout", dout, 8'h13);
      check("ar_oe", oe, 1);
      check("ar_no_inc", addr, 5'h13);

      n = wr_addr_q.size();
      rc = rd_cnt;
      saw_ack = 1'b0;
      @(negedge clk);
      nWrite = 1'b0; pport_din = 8'h77; nDataStr = 1'b0;
      repeat (2) @(negedge clk);
      nDataStr = 1'b1;
      repeat (10) @(negedge clk);
      check("short_no_ack", saw_ack, 0);
      check("short_no_wr", wr_addr_q.size(), n);
      check("short_no_rd", rd_cnt, rc);
      check("short_addr", addr, 5'h13);

      @(negedge clk);
      nWrite = 1'b0; pport_din = 8'h44; nDataStr = 1'b0;
      ack = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!nWait) begin
            ack = 1'b1;
            break;
         end
      end
      check("rstmid_ack", ack, 1);
      n = wr_addr_q.size();
      nReset = 1'b0;
      #1;
      check("rstmid_nwait", nWait, 1);
      check("rstmid_oe", pport_oe, 0);
      check("rstmid_addr", addr, 0);
      @(negedge clk);
      nDataStr = 1'b1; nWrite = 1'b1;
      repeat (3) @(negedge clk);
      nReset = 1'b1;
      repeat (8) @(negedge clk);
      check("rstmid_no_wr", wr_addr_q.size(), n);

      n = wr_addr_q.size();
      epp_cycle(1, 1, 0, 8'h0A, ack, dout, oe);
      check("both_ack", ack, 1);
      check("both_addr", addr, 5'h0A);
      check("both_no_wr", wr_addr_q.size(), n);

`ifdef EPP_TIMEOUT_EN
      @(negedge clk);
      nWrite = 1'b0; pport_din = 8'h55; nDataStr = 1'b0;
      for (int i = 0; i < 20 && nWait; i++) @(negedge clk);
      n = 0;
      while (!nWait && n < 40) begin
         n++;
         @(negedge clk);
      end
      nDataStr = 1'b1; nWrite = 1'b1;
      check("to_ack_cycles", n, 16);
      check("to_set", timeout, 1);
      repeat (10) @(negedge clk);
      check("to_sticky", timeout, 1);
      check("to_addr_inc", addr, 5'h0B);
      timeout_clr = 1'b1;
      @(negedge clk);
      timeout_clr = 1'b0;
      check("to_clr", timeout, 0);
`else
      check("to_tied", timeout, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
